reg_bridge_mw: RTL

- Parametrised successor of the single-register-block decoder: one bus slave port fanned out to NUM_REGS read/write control registers and NUM_WIN memory windows.
- Adds a request/response state machine, byte write strobes, per-window multi-cycle handshakes, an access timeout and an error response.
- Sits between the host register bus and the RAM/ROM macro instances (1-cycle-ready memories).

---
 rtl/reg_bridge_mw_if.sv | 35 +++
 rtl/reg_bridge_mw.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/reg_bridge_mw_if.sv
// Host register bus plus memory-window side of reg_bridge_mw, bundled as one interface.
// slave: the bridge itself; master: the host/memory environment driving it.
interface reg_bridge_mw_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_WIN = 2,
    parameter int MADDR_W = 5
);
    logic [ADDR_W-1:0]         bus_addr;
    logic                      bus_we;
    logic                      bus_re;
    logic [DATA_W-1:0]         bus_wdata;
    logic [DATA_W/8-1:0]       bus_wstrb;
    logic [DATA_W-1:0]         bus_rdata;
    logic                      bus_ready;
    logic                      bus_err;

    logic [MADDR_W-1:0]        mem_addr;
    logic [NUM_WIN-1:0]        mem_we;
    logic [NUM_WIN-1:0]        mem_re;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W/8-1:0]       mem_wstrb;
    logic [NUM_WIN*DATA_W-1:0] mem_rdata;
    logic [NUM_WIN-1:0]        mem_ready;

    modport slave (
        input  bus_addr, bus_we, bus_re, bus_wdata, bus_wstrb, mem_rdata, mem_ready,
        output bus_rdata, bus_ready, bus_err, mem_addr, mem_we, mem_re, mem_wdata, mem_wstrb
    );

    modport master (
        output bus_addr, bus_we, bus_re, bus_wdata, bus_wstrb, mem_rdata, mem_ready,
        input  bus_rdata, bus_ready, bus_err, mem_addr, mem_we, mem_re, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/reg_bridge_mw.sv
// Bus slave fanning out to NUM_REGS control registers and NUM_WIN memory windows with timeout.
// Optional saturating error counter at byte address 4*NUM_REGS: define REG_BRIDGE_ERRCNT_EN.
module reg_bridge_mw #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4,
    parameter logic [NUM_REGS*DATA_W-1:0] REG_RESET = '0,
    parameter int NUM_WIN  = 2,
    parameter int WIN_BASE = 'h100,
    parameter int WIN_SIZE = 'h80,
    parameter int TIMEOUT  = 15
) (
    input  logic                       clk,
    input  logic                       rst_b,
    reg_bridge_mw_if.slave             bus,
    output logic [NUM_REGS*DATA_W-1:0] reg_q
);
    localparam int STRB_W    = DATA_W / 8;
    localparam int MADDR_W   = (WIN_SIZE > 4) ? $clog2(WIN_SIZE / 4) : 1;
    localparam int WIN_IDX_W = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
    localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int WIN_SH    = $clog2(WIN_SIZE);

    localparam logic [ADDR_W-1:0] REG_END = ADDR_W'(4 * NUM_REGS);
    localparam logic [ADDR_W-1:0] WIN_LO  = ADDR_W'(WIN_BASE);
    localparam logic [ADDR_W-1:0] WIN_HI  = ADDR_W'(WIN_BASE + NUM_WIN * WIN_SIZE);
    localparam logic [7:0]        TO_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MEM_REQ  = 2'd1;
    localparam logic [1:0] S_MEM_WAIT = 2'd2;
    localparam logic [1:0] S_RESP     = 2'd3;

    logic [1:0]                         r_state;
    logic [NUM_REGS-1:0][DATA_W-1:0]    r_regs;
    logic [DATA_W-1:0]                  r_rdata;
    logic                               r_ready;
    logic                               r_err;
    logic [NUM_WIN-1:0]                 r_mem_we;
    logic [NUM_WIN-1:0]                 r_mem_re;
    logic [MADDR_W-1:0]                 r_mem_addr;
    logic [DATA_W-1:0]                  r_mem_wdata;
    logic [STRB_W-1:0]                  r_mem_wstrb;
    logic [WIN_IDX_W-1:0]               r_win;
    logic                               r_write;
    logic [7:0]                         r_cnt;

    logic                               w_req;
    logic                               w_bad_align;
    logic                               w_reg_hit;
    logic                               w_win_hit;
    logic [REG_IDX_W-1:0]               w_reg_idx;
    logic [WIN_IDX_W-1:0]               w_win_idx;
    logic [MADDR_W-1:0]                 w_mem_addr;

`ifdef REG_BRIDGE_ERRCNT_EN
    logic [7:0]                         r_errcnt;
    logic                               w_errcnt_hit;

    if ((4 * NUM_REGS >= WIN_BASE) && (4 * NUM_REGS < WIN_BASE + WIN_SIZE)) begin : g_errcnt_overlap
        $error("reg_bridge_mw: error counter address overlaps window 0");
    end

    assign w_errcnt_hit = !w_bad_align && (bus.bus_addr == REG_END);
`endif

    always_comb begin
        w_req       = bus.bus_we | bus.bus_re;
        w_bad_align = bus.bus_addr[1:0] != 2'b00;
        w_reg_hit   = !w_bad_align && (bus.bus_addr < REG_END);
        w_win_hit   = !w_bad_align && (bus.bus_addr >= WIN_LO) && (bus.bus_addr < WIN_HI);
        w_reg_idx   = REG_IDX_W'(bus.bus_addr >> 2);
        w_win_idx   = WIN_IDX_W'((bus.bus_addr - WIN_LO) >> WIN_SH);
        w_mem_addr  = (WIN_SIZE > 4) ? MADDR_W'((bus.bus_addr - WIN_LO) >> 2) : '0;
    end

    // Writes win over reads when both are requested; only one access is ever in flight.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state     <= S_IDLE;
            r_regs      <= REG_RESET;
            r_rdata     <= '0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_mem_we    <= '0;
            r_mem_re    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_win       <= '0;
            r_write     <= 1'b0;
            r_cnt       <= '0;
`ifdef REG_BRIDGE_ERRCNT_EN
            r_errcnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_state <= S_RESP;
                        r_ready <= 1'b1;
                        r_err   <= 1'b0;
                        if (w_reg_hit) begin
                            if (bus.bus_we) begin
                                for (int b = 0; b < STRB_W; b++) begin
                                    if (bus.bus_wstrb[b]) begin
                                        r_regs[w_reg_idx][b*8 +: 8] <= bus.bus_wdata[b*8 +: 8];
                                    end
                                end
                            end else begin
                                r_rdata <= r_regs[w_reg_idx];
                            end
                        end
`ifdef REG_BRIDGE_ERRCNT_EN
                        else if (w_errcnt_hit) begin
                            if (bus.bus_we) begin
                                r_errcnt <= '0;
                            end else begin
                                r_rdata <= DATA_W'(r_errcnt);
                            end
                        end
`endif
                        else if (w_win_hit) begin
                            r_state     <= S_MEM_REQ;
                            r_ready     <= 1'b0;
                            r_win       <= w_win_idx;
                            r_write     <= bus.bus_we;
                            r_mem_addr  <= w_mem_addr;
                            r_mem_wdata <= bus.bus_wdata;
                            r_mem_wstrb <= bus.bus_wstrb;
                            r_mem_we    <= bus.bus_we ? (NUM_WIN'(1) << w_win_idx) : '0;
                            r_mem_re    <= bus.bus_we ? '0 : (NUM_WIN'(1) << w_win_idx);
                        end else begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_MEM_REQ: begin
                    r_mem_we <= '0;
                    r_mem_re <= '0;
                    r_cnt    <= '0;
                    r_state  <= S_MEM_WAIT;
                end
                // A ready arriving in the final allowed cycle still beats the timeout.
                S_MEM_WAIT: begin
                    if (bus.mem_ready[r_win]) begin
                        r_rdata <= r_write ? '0 : bus.mem_rdata[int'(r_win)*DATA_W +: DATA_W];
                        r_err   <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_RESP;
                    end else if (r_cnt == TO_LAST) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
`ifdef REG_BRIDGE_ERRCNT_EN
                    if (r_err && (r_errcnt != 8'hFF)) begin
                        r_errcnt <= r_errcnt + 8'd1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.bus_rdata = r_rdata;
    assign bus.bus_ready = r_ready;
    assign bus.bus_err   = r_err;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_re    = r_mem_re;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wstrb = r_mem_wstrb;
    assign reg_q         = r_regs;
endmodule
